// File: rtl/cobra_pkg.sv
// cobra_pkg: shared types for the snake-body controller.
//   cell_e  : map cell codes written on the cobra write port
//   dir_e   : 2-bit movement direction
//   state_e : cobra write-sequencer states
//   dir_opposite() : the direction a move may never reverse into
package cobra_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BODY  = 2'd1,
    CELL_HEAD  = 2'd2
  } cell_e;

  // Up/down and left/right differ only in bit 0, so flipping it gives the opposite.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ERASE,
    ST_BODY,
    ST_HEAD
  } state_e;

  function automatic dir_e dir_opposite(dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/cobra_if.sv
// cobra_if: map write port driven by cobra and consumed by the mapa block.
//   cobra_write : one-cycle write strobe
//   cobra_dado  : cell code (0 empty, 1 body, 2 head)
//   cobra_x/y   : cell column / row
// master = cobra (writer), slave = map memory.
interface cobra_if #(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 5
);
  logic              cobra_write;
  logic [1:0]        cobra_dado;
  logic [X_BITS-1:0] cobra_x;
  logic [Y_BITS-1:0] cobra_y;

  modport master (output cobra_write, cobra_dado, cobra_x, cobra_y);
  modport slave  (input  cobra_write, cobra_dado, cobra_x, cobra_y);
endinterface

// File: rtl/cobra_tick.sv
// cobra_tick: movement pacing for cobra.
//   clk, reset : clock, asynchronous active-low reset
//   halt_i     : freezes the counter (no ticks generated while high)
//   take_i     : the sequencer has accepted the pending tick
//   pend_o     : a tick is waiting to be serviced (at most one is held)
module cobra_tick #(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic halt_i,
  input  logic take_i,
  output logic pend_o
);
  localparam int CW = $clog2(TICK_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          pend_q;
  logic          wrap;

  assign wrap = !halt_i && (cnt_q == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (!halt_i) cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      // A fresh tick on the same edge as a take keeps one pending.
      pend_q <= wrap | (pend_q & ~take_i);
    end
  end

  assign pend_o = pend_q;
endmodule

// File: rtl/cobra.sv
// cobra: snake-body controller. Owns the body as a circular coordinate buffer,
// moves once per tick and redraws the affected cells through the map port.
//   clk, reset              : clock, asynchronous active-low reset
//   up/down/left/right      : level direction requests (priority in that order)
//   grow                    : one-cycle fruit pulse, queued up to 7
//   halt                    : freeze movement (running sequence completes)
//   wr (cobra_if.master)    : map write port
//   head_x/head_y, length   : current head and body length
//   moved                   : one-cycle pulse when a move completes
//   busy                    : write sequence in progress
//   wall_hit                : only without COBRA_WRAP_EN; sticky wall collision
// Build option: define COBRA_WRAP_EN to wrap at map edges instead of stopping.
module cobra
  import cobra_pkg::*;
#(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int X_BITS      = 6,
  parameter int Y_BITS      = 5,
  parameter int MAX_LEN     = 64,
  parameter int START_LEN   = 3,
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic              grow,
  input  logic              halt,
  cobra_if.master           wr,
  output logic [X_BITS-1:0] head_x,
  output logic [Y_BITS-1:0] head_y,
  output logic [6:0]        length,
  output logic              moved,
  output logic              busy
`ifndef COBRA_WRAP_EN
  ,
  output logic              wall_hit
`endif
);
  localparam int HX = MAPA_WIDTH / 2;
  localparam int HY = MAPA_HEIGHT / 2;
  localparam int PW = $clog2(MAX_LEN);

  state_e            state_q;
  logic [6:0]        init_q;
  logic              wr_q, moved_q, busy_q, grew_q;
  cell_e             dado_q;
  logic [X_BITS-1:0] wx_q, head_x_q, new_x_q, nx;
  logic [Y_BITS-1:0] wy_q, head_y_q, new_y_q, ny;
  logic [6:0]        len_q;
  dir_e              dir_q, next_dir_q, next_dir_d, req_dir;
  logic              req_vld;
  logic [2:0]        grow_q, grow_d;
  logic [PW-1:0]     hptr_q, tptr_q, hptr_nx;
  logic [X_BITS-1:0] bx_q [MAX_LEN];
  logic [Y_BITS-1:0] by_q [MAX_LEN];
  logic              tick_pend, start, take_grow, grows, off, blocked, stopped;

  cobra_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .halt_i (halt),
    .take_i (start),
    .pend_o (tick_pend)
  );

`ifdef COBRA_WRAP_EN
  logic unused_off;
  assign unused_off = off;
  assign blocked    = 1'b0;
  assign stopped    = 1'b0;
`else
  logic wall_q;
  assign blocked  = off;
  assign stopped  = wall_q;
  assign wall_hit = wall_q;
`endif

  assign start     = (state_q == ST_IDLE) && tick_pend && !halt && !stopped;
  assign take_grow = start && !blocked && (grow_q != 3'd0);
  // At full length a pending grow is spent but the tail still moves.
  assign grows     = take_grow && (len_q != 7'(MAX_LEN));
  assign hptr_nx   = hptr_q + 1'b1;

  // Highest-priority request; a reversal of the applied direction is dropped.
  always_comb begin
    req_vld = 1'b1;
    req_dir = DIR_RIGHT;
    if (up)         req_dir = DIR_UP;
    else if (down)  req_dir = DIR_DOWN;
    else if (left)  req_dir = DIR_LEFT;
    else if (right) req_dir = DIR_RIGHT;
    else            req_vld = 1'b0;
    next_dir_d = (req_vld && req_dir != dir_opposite(dir_q)) ? req_dir : next_dir_q;
  end

  // Candidate head; off flags a step across the map edge (value already wrapped).
  always_comb begin
    nx  = head_x_q;
    ny  = head_y_q;
    off = 1'b0;
    case (next_dir_q)
      DIR_UP:
        if (head_y_q == '0) begin ny = Y_BITS'(MAPA_HEIGHT - 1); off = 1'b1; end
        else ny = head_y_q - 1'b1;
      DIR_DOWN:
        if (head_y_q == Y_BITS'(MAPA_HEIGHT - 1)) begin ny = '0; off = 1'b1; end
        else ny = head_y_q + 1'b1;
      DIR_LEFT:
        if (head_x_q == '0) begin nx = X_BITS'(MAPA_WIDTH - 1); off = 1'b1; end
        else nx = head_x_q - 1'b1;
      default:
        if (head_x_q == X_BITS'(MAPA_WIDTH - 1)) begin nx = '0; off = 1'b1; end
        else nx = head_x_q + 1'b1;
    endcase
  end

  // Pending grows: saturating at 7, a simultaneous pulse and consume cancel.
  always_comb begin
    grow_d = grow_q;
    if (grow && !take_grow) begin
      if (grow_q != 3'd7) grow_d = grow_q + 3'd1;
    end else if (!grow && take_grow) begin
      grow_d = grow_q - 3'd1;
    end
  end

  // Outputs are registered on entry to a state, so each write shows while its
  // state is current and the strobe drops on the way out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_q     <= '0;
      wr_q       <= 1'b0;
      dado_q     <= CELL_EMPTY;
      wx_q       <= '0;
      wy_q       <= '0;
      moved_q    <= 1'b0;
      busy_q     <= 1'b1;
      head_x_q   <= X_BITS'(HX);
      head_y_q   <= Y_BITS'(HY);
      new_x_q    <= '0;
      new_y_q    <= '0;
      len_q      <= 7'(START_LEN);
      dir_q      <= DIR_RIGHT;
      next_dir_q <= DIR_RIGHT;
      grow_q     <= '0;
      grew_q     <= 1'b0;
      hptr_q     <= PW'(START_LEN - 1);
      tptr_q     <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        bx_q[i] <= (i < START_LEN) ? X_BITS'(HX - START_LEN + 1 + i) : '0;
        by_q[i] <= Y_BITS'(HY);
      end
`ifndef COBRA_WRAP_EN
      wall_q     <= 1'b0;
`endif
    end else begin
      next_dir_q <= next_dir_d;
      grow_q     <= grow_d;
      wr_q       <= 1'b0;
      moved_q    <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (init_q == 7'(START_LEN)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            wr_q   <= 1'b1;
            dado_q <= (init_q == 7'(START_LEN - 1)) ? CELL_HEAD : CELL_BODY;
            wx_q   <= bx_q[init_q[PW-1:0]];
            wy_q   <= by_q[init_q[PW-1:0]];
            init_q <= init_q + 7'd1;
          end
        end
        ST_IDLE: begin
          if (start) begin
            dir_q <= next_dir_q;
            if (blocked) begin
`ifndef COBRA_WRAP_EN
              wall_q <= 1'b1;
`endif
            end else begin
              new_x_q <= nx;
              new_y_q <= ny;
              busy_q  <= 1'b1;
              wr_q    <= 1'b1;
              grew_q  <= grows;
              if (grows) begin
                state_q <= ST_BODY;
                dado_q  <= CELL_BODY;
                wx_q    <= head_x_q;
                wy_q    <= head_y_q;
              end else begin
                state_q <= ST_ERASE;
                dado_q  <= CELL_EMPTY;
                wx_q    <= bx_q[tptr_q];
                wy_q    <= by_q[tptr_q];
                tptr_q  <= tptr_q + 1'b1;
              end
            end
          end
        end
        ST_ERASE: begin
          state_q <= ST_BODY;
          wr_q    <= 1'b1;
          dado_q  <= CELL_BODY;
          wx_q    <= head_x_q;
          wy_q    <= head_y_q;
        end
        ST_BODY: begin
          state_q       <= ST_HEAD;
          wr_q          <= 1'b1;
          dado_q        <= CELL_HEAD;
          wx_q          <= new_x_q;
          wy_q          <= new_y_q;
          hptr_q        <= hptr_nx;
          bx_q[hptr_nx] <= new_x_q;
          by_q[hptr_nx] <= new_y_q;
        end
        ST_HEAD: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          moved_q  <= 1'b1;
          head_x_q <= new_x_q;
          head_y_q <= new_y_q;
          if (grew_q) len_q <= len_q + 7'd1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr.cobra_write = wr_q;
  assign wr.cobra_dado  = dado_q;
  assign wr.cobra_x     = wx_q;
  assign wr.cobra_y     = wy_q;
  assign head_x         = head_x_q;
  assign head_y         = head_y_q;
  assign length         = len_q;
  assign moved          = moved_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_cobra.sv
// tb_cobra: self-checking bench for cobra with a short tick period.
module tb_cobra;
  localparam int MW = 40, MH = 30, XB = 6, YB = 5, MAXL = 64, SLEN = 3, TICK = 16;

  logic clk = 1'b0, reset = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, grow = 1'b0, halt = 1'b0;
  logic [XB-1:0] head_x;
  logic [YB-1:0] head_y;
  logic [6:0]    length;
  logic          moved, busy;
`ifndef COBRA_WRAP_EN
  logic          wall_hit;
`endif

  cobra_if #(.X_BITS(XB), .Y_BITS(YB)) bus ();

  cobra #(
    .MAPA_WIDTH(MW), .MAPA_HEIGHT(MH), .X_BITS(XB), .Y_BITS(YB),
    .MAX_LEN(MAXL), .START_LEN(SLEN), .TICK_CYCLES(TICK)
  ) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .grow(grow), .halt(halt), .wr(bus), .head_x(head_x), .head_y(head_y),
    .length(length), .moved(moved), .busy(busy)
`ifndef COBRA_WRAP_EN
    , .wall_hit(wall_hit)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit wr; int d; int x; int y; bit mv; bit bz; int hx; int hy; int len;
  } exp_t;

  exp_t sched[$];
  int   bx[$], by[$];             // body cells, tail first
  int   mhx, mhy, mlen, mdir, mnext, mgrow, tcnt;
  bit   mpend, mwall;
  int   opp [4] = '{1, 0, 3, 2};  // 0 up, 1 down, 2 left, 3 right

  function automatic exp_t mk(bit w, int d, int x, int y, bit mv, bit bz, int hx, int hy, int len);
    exp_t e;
    e.wr = w; e.d = d; e.x = x; e.y = y; e.mv = mv; e.bz = bz;
    e.hx = hx; e.hy = hy; e.len = len;
    return e;
  endfunction

  task automatic model_reset();
    sched.delete(); bx.delete(); by.delete();
    mhx = MW / 2; mhy = MH / 2; mlen = SLEN; mdir = 3; mnext = 3;
    mgrow = 0; tcnt = 0; mpend = 0; mwall = 0;
    for (int i = 0; i < SLEN; i++) begin
      bx.push_back(mhx - SLEN + 1 + i); by.push_back(mhy);
      sched.push_back(mk(1, (i == SLEN - 1) ? 2 : 1, mhx - SLEN + 1 + i, mhy, 0, 1, mhx, mhy, mlen));
    end
    sched.push_back(mk(0, 0, 0, 0, 0, 0, mhx, mhy, mlen));
  endtask

  task automatic model_step();
    exp_t e;
    int od, nhx, nhy, req, ohx, ohy, olen;
    bit off, grows;
    od = mdir;
    // A move may begin only when the previous sequence has fully drained.
    if (sched.size() == 0 && mpend && !halt && !mwall) begin
      mpend = 0;
      mdir  = mnext;
      nhx = mhx + ((mdir == 3) ? 1 : (mdir == 2) ? -1 : 0);
      nhy = mhy + ((mdir == 1) ? 1 : (mdir == 0) ? -1 : 0);
      off = (nhx < 0) || (nhx >= MW) || (nhy < 0) || (nhy >= MH);
`ifdef COBRA_WRAP_EN
      nhx = (nhx + MW) % MW;
      nhy = (nhy + MH) % MH;
      off = 0;
`endif
      if (off) mwall = 1;
      else begin
        ohx = mhx; ohy = mhy; olen = mlen; grows = 0;
        if (mgrow > 0) begin mgrow--; grows = (mlen < MAXL); end
        if (!grows) begin
          sched.push_back(mk(1, 0, bx[0], by[0], 0, 1, ohx, ohy, olen));
          void'(bx.pop_front()); void'(by.pop_front());
        end
        sched.push_back(mk(1, 1, ohx, ohy, 0, 1, ohx, ohy, olen));
        sched.push_back(mk(1, 2, nhx, nhy, 0, 1, ohx, ohy, olen));
        bx.push_back(nhx); by.push_back(nhy);
        mhx = nhx; mhy = nhy;
        if (grows) mlen++;
        sched.push_back(mk(0, 0, 0, 0, 1, 0, mhx, mhy, mlen));
      end
    end
    if (grow && mgrow < 7) mgrow++;
    if (!halt) begin
      tcnt++;
      if (tcnt == TICK) begin tcnt = 0; mpend = 1; end
    end
    req = -1;
    if (up) req = 0; else if (down) req = 1; else if (left) req = 2; else if (right) req = 3;
    if (req >= 0 && req != opp[od]) mnext = req;

    if (sched.size() > 0) e = sched.pop_front();
    else e = mk(0, 0, 0, 0, 0, 0, mhx, mhy, mlen);

    chk("write", bus.cobra_write, e.wr);
    if (e.wr) begin
      chk("dado", bus.cobra_dado, e.d);
      chk("wx", bus.cobra_x, e.x);
      chk("wy", bus.cobra_y, e.y);
    end
    chk("moved", moved, e.mv);
    chk("busy", busy, e.bz);
    chk("head_x", head_x, e.hx);
    chk("head_y", head_y, e.hy);
    chk("length", length, e.len);
`ifndef COBRA_WRAP_EN
    chk("wall_hit", wall_hit, mwall);
`endif
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) model_reset();
    else model_step();
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_moved(input int n, input int bound);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (moved) seen++;
    end
    chk("moves_seen", seen, n);
  endtask

  task automatic chk_reset_state();
    chk("rst_write", bus.cobra_write, 0);
    chk("rst_busy", busy, 1);
    chk("rst_moved", moved, 0);
    chk("rst_head_x", head_x, 20);
    chk("rst_head_y", head_y, 15);
    chk("rst_length", length, 3);
`ifndef COBRA_WRAP_EN
    chk("rst_wall", wall_hit, 0);
`endif
  endtask

  initial begin
    int wcnt, mcnt;
    bit found;
    repeat (3) @(negedge clk);
    chk_reset_state();
    reset = 1'b1;

    @(posedge clk); #2;
    chk("init0_x", bus.cobra_x, 18); chk("init0_y", bus.cobra_y, 15); chk("init0_d", bus.cobra_dado, 1);
    @(posedge clk); #2;
    chk("init1_x", bus.cobra_x, 19); chk("init1_d", bus.cobra_dado, 1);
    @(posedge clk); #2;
    chk("init2_x", bus.cobra_x, 20); chk("init2_d", bus.cobra_dado, 2);
    @(posedge clk); #2;
    chk("init_done_busy", busy, 0);

    wait_moved(1, 40);
    chk("mv1_x", head_x, 21); chk("mv1_y", head_y, 15);

    @(negedge clk); left = 1'b1;
    repeat (5) @(negedge clk);
    left = 1'b0; up = 1'b1;
    wait_moved(1, 40);
    up = 1'b0;
    chk("mv2_x", head_x, 21); chk("mv2_y", head_y, 14);

    right = 1'b1;
    wait_moved(1, 40);
    right = 1'b0;
    chk("mv3_x", head_x, 22); chk("mv3_y", head_y, 14);

    @(negedge clk); grow = 1'b1;
    @(negedge clk); grow = 1'b0;
    wait_moved(1, 40);
    chk("grow_x", head_x, 23); chk("grow_len", length, 4);

    halt = 1'b1;
    wcnt = 0;
    repeat (3 * TICK) begin
      @(negedge clk);
      if (bus.cobra_write) wcnt++;
    end
    chk("halt_writes", wcnt, 0);
    halt = 1'b0;

    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.cobra_write && bus.cobra_dado == 2'd1) found = 1;
    end
    chk("body_seen", found, 1);
    reset = 1'b0;
    #1;
    chk_reset_state();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("reinit_wr", bus.cobra_write, 1);
    chk("reinit_x", bus.cobra_x, 18); chk("reinit_d", bus.cobra_dado, 1);

    wait_moved(19, 19 * TICK + 64);
    chk("edge_x", head_x, 39); chk("edge_y", head_y, 15);
`ifdef COBRA_WRAP_EN
    wait_moved(1, 40);
    chk("wrap_x", head_x, 0); chk("wrap_y", head_y, 15);
`else
    wcnt = 0; mcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.cobra_write) wcnt++;
      if (moved) mcnt++;
    end
    chk("wall_writes", wcnt, 0);
    chk("wall_moves", mcnt, 0);
    chk("wall_flag", wall_hit, 1);
    chk("wall_head_x", head_x, 39);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
